// File: rtl/dht_pkg.sv
// Shared types, frame geometry, default microsecond timings and checksum
// helper for the DHT22-class single-wire responder.
package dht_pkg;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    HOST_LOW = 4'd1,
    HOST_REL = 4'd2,
    ACK_LOW  = 4'd3,
    ACK_HIGH = 4'd4,
    BIT_LOW  = 4'd5,
    BIT_HIGH = 4'd6,
    TAIL     = 4'd7,
    HOLDOFF  = 4'd8
  } dht_state_e;

  localparam int FRAME_BITS = 40;
  localparam int TMR_W      = 16;

  localparam int START_MIN_US_DEF = 800;
  localparam int REL_WAIT_US_DEF  = 30;
  localparam int ACK_US_DEF       = 80;
  localparam int BIT_LOW_US_DEF   = 50;
  localparam int BIT0_HIGH_US_DEF = 27;
  localparam int BIT1_HIGH_US_DEF = 70;
  localparam int HOLDOFF_US_DEF   = 2000;

  // Byte-wise sum of humidity and temperature words; the carry out of bit 7 is dropped.
  function automatic logic [7:0] dht_csum(input logic [15:0] hum, input logic [15:0] temp);
    logic [7:0] sum;
    sum = hum[15:8] + hum[7:0] + temp[15:8] + temp[7:0];
    return sum;
  endfunction

endpackage

// File: rtl/dht_us_timer.sv
// Microsecond prescaler plus loadable down-counting phase timer. Loading
// restarts the prescaler so every phase lasts exactly load_val microseconds.
module dht_us_timer
  import dht_pkg::*;
#(
  parameter int TICKS_PER_US = 50,
  parameter int CNT_W        = TMR_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done,
  output logic             zero
);

  localparam int PRE_W = (TICKS_PER_US > 1) ? $clog2(TICKS_PER_US) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICKS_PER_US - 1);
  localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [PRE_W-1:0] pre_r;
  logic [CNT_W-1:0] cnt_r;
  logic             tick_s;

  assign tick_s = (pre_r == PRE_LAST);
  assign zero   = (cnt_r == {CNT_W{1'b0}});
  // done marks the last tick of the phase so the caller switches exactly on the boundary
  assign done   = tick_s && (cnt_r == CNT_ONE);

  // Prescaler and phase counter; the counter saturates at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_r <= {PRE_W{1'b0}};
      cnt_r <= {CNT_W{1'b0}};
    end else if (load) begin
      pre_r <= {PRE_W{1'b0}};
      cnt_r <= load_val;
    end else begin
      if (tick_s) begin
        pre_r <= {PRE_W{1'b0}};
      end else begin
        pre_r <= pre_r + PRE_ONE;
      end
      if (tick_s && !zero) begin
        cnt_r <= cnt_r - CNT_ONE;
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

endmodule

// File: rtl/dht_responder.sv
// DHT22-class single-wire sensor emulator (responder side). Optional build macro
// DHT_FAULT_INJECT_EN adds fault_crc_i, which inverts the transmitted checksum.
module dht_responder
  import dht_pkg::*;
#(
  parameter int CLK_HZ       = 50000000,
  parameter int START_MIN_US = START_MIN_US_DEF,
  parameter int REL_WAIT_US  = REL_WAIT_US_DEF,
  parameter int ACK_US       = ACK_US_DEF,
  parameter int BIT_LOW_US   = BIT_LOW_US_DEF,
  parameter int BIT0_HIGH_US = BIT0_HIGH_US_DEF,
  parameter int BIT1_HIGH_US = BIT1_HIGH_US_DEF,
  parameter int HOLDOFF_US   = HOLDOFF_US_DEF
) (
  input  logic        clk50M,
  input  logic        rst_n,
  input  logic        data_i,
  output logic        data_oe,
  input  logic [15:0] hum_i,
  input  logic [15:0] temp_i,
`ifdef DHT_FAULT_INJECT_EN
  input  logic        fault_crc_i,
`endif
  output logic        busy,
  output logic        frame_done,
  output logic        err_collision
);

  localparam int TICKS_PER_US = CLK_HZ / 1000000;
  localparam logic [5:0] LAST_BIT = 6'(FRAME_BITS - 1);

  dht_state_e            state_r, state_s;
  logic                  sync1_r, ds_r, ds_d_r;
  logic [FRAME_BITS-1:0] frame_r;
  logic [5:0]            bit_idx_r;
  logic [1:0]            rel_cnt_r;
  logic                  tmr_load_s, tmr_done_s, tmr_zero_s;
  logic [TMR_W-1:0]      tmr_val_s;
  logic                  ds_fall_s, collide_s, accept_s;
  logic                  data_oe_s, busy_s, frame_done_s, err_collision_s;
  logic [7:0]            csum_s, csum_tx_s;

  dht_us_timer #(
    .TICKS_PER_US(TICKS_PER_US),
    .CNT_W       (TMR_W)
  ) u_timer (
    .clk     (clk50M),
    .rst_n   (rst_n),
    .load    (tmr_load_s),
    .load_val(tmr_val_s),
    .done    (tmr_done_s),
    .zero    (tmr_zero_s)
  );

  // Line synchronizer; idles high so reset release cannot fake a falling edge
  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b1;
      ds_r    <= 1'b1;
      ds_d_r  <= 1'b1;
    end else begin
      sync1_r <= data_i;
      ds_r    <= sync1_r;
      ds_d_r  <= ds_r;
    end
  end

  assign ds_fall_s = ds_d_r & ~ds_r;
  // A low line only counts as foreign once the synchronizer has caught up with our release
  assign collide_s = (rel_cnt_r == 2'd3) & ~ds_r;

  // State register
  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (ds_fall_s) state_s = HOST_LOW;
        else           state_s = IDLE;
      end
      HOST_LOW: begin
        if (!ds_r)           state_s = HOST_LOW;
        else if (tmr_zero_s) state_s = HOST_REL;
        else                 state_s = IDLE;
      end
      HOST_REL: begin
        if (collide_s)       state_s = HOLDOFF;
        else if (tmr_done_s) state_s = ACK_LOW;
        else                 state_s = HOST_REL;
      end
      ACK_LOW: begin
        if (tmr_done_s) state_s = ACK_HIGH;
        else            state_s = ACK_LOW;
      end
      ACK_HIGH: begin
        if (collide_s)       state_s = HOLDOFF;
        else if (tmr_done_s) state_s = BIT_LOW;
        else                 state_s = ACK_HIGH;
      end
      BIT_LOW: begin
        if (tmr_done_s) state_s = BIT_HIGH;
        else            state_s = BIT_LOW;
      end
      BIT_HIGH: begin
        if (collide_s)                           state_s = HOLDOFF;
        else if (tmr_done_s && bit_idx_r == 6'd0) state_s = TAIL;
        else if (tmr_done_s)                     state_s = BIT_LOW;
        else                                     state_s = BIT_HIGH;
      end
      TAIL: begin
        if (tmr_done_s) state_s = HOLDOFF;
        else            state_s = TAIL;
      end
      HOLDOFF: begin
        if (tmr_done_s) state_s = IDLE;
        else            state_s = HOLDOFF;
      end
      default: state_s = IDLE;
    endcase
  end

  // Output and phase-timer control, decoded from the state being entered
  always_comb begin
    tmr_load_s = (state_s != state_r);
    tmr_val_s  = {TMR_W{1'b0}};
    case (state_s)
      HOST_LOW:         tmr_val_s = TMR_W'(START_MIN_US);
      HOST_REL:         tmr_val_s = TMR_W'(REL_WAIT_US);
      ACK_LOW, ACK_HIGH: tmr_val_s = TMR_W'(ACK_US);
      BIT_LOW, TAIL:    tmr_val_s = TMR_W'(BIT_LOW_US);
      BIT_HIGH: begin
        if (frame_r[bit_idx_r]) tmr_val_s = TMR_W'(BIT1_HIGH_US);
        else                    tmr_val_s = TMR_W'(BIT0_HIGH_US);
      end
      HOLDOFF:          tmr_val_s = TMR_W'(HOLDOFF_US);
      default:          tmr_val_s = {TMR_W{1'b0}};
    endcase
    data_oe_s       = (state_s == ACK_LOW) || (state_s == BIT_LOW) || (state_s == TAIL);
    busy_s          = (state_s != IDLE) && (state_s != HOST_LOW);
    frame_done_s    = (state_r == TAIL) && (state_s == HOLDOFF);
    err_collision_s = (state_s == HOLDOFF) && (state_r != TAIL) && (state_r != HOLDOFF);
    accept_s        = (state_r == HOST_LOW) && (state_s == HOST_REL);
  end

  // Checksum that goes on the wire
  always_comb begin
    csum_s = dht_csum(hum_i, temp_i);
`ifdef DHT_FAULT_INJECT_EN
    if (fault_crc_i) csum_tx_s = ~csum_s;
    else             csum_tx_s = csum_s;
`else
    csum_tx_s = csum_s;
`endif
  end

  // Registered outputs, frame snapshot, bit index and release-skew counter
  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) begin
      data_oe       <= 1'b0;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
      err_collision <= 1'b0;
      frame_r       <= {FRAME_BITS{1'b0}};
      bit_idx_r     <= 6'd0;
      rel_cnt_r     <= 2'd0;
    end else begin
      data_oe       <= data_oe_s;
      busy          <= busy_s;
      frame_done    <= frame_done_s;
      err_collision <= err_collision_s;
      if (accept_s) begin
        frame_r   <= {hum_i, temp_i, csum_tx_s};
        bit_idx_r <= LAST_BIT;
      end else if ((state_r == BIT_HIGH) && (state_s == BIT_LOW)) begin
        bit_idx_r <= bit_idx_r - 6'd1;
      end else begin
        bit_idx_r <= bit_idx_r;
      end
      if (data_oe) begin
        rel_cnt_r <= 2'd0;
      end else if (rel_cnt_r != 2'd3) begin
        rel_cnt_r <= rel_cnt_r + 2'd1;
      end else begin
        rel_cnt_r <= rel_cnt_r;
      end
    end
  end

endmodule

// File: tb/tb_dht_responder.sv
// Directed bench for dht_responder: acts as host on an open-drain line, decodes
// the reply from pulse widths and checks it against a byte-sum frame model.
module tb_dht_responder;

  localparam int CLK_HZ     = 2000000;
  localparam int T          = CLK_HZ / 1000000;
  localparam int REL_US     = 30;
  localparam int ACK_US     = 80;
  localparam int BLO_US     = 50;
  localparam int B0_US      = 27;
  localparam int B1_US      = 70;
  localparam int HOLDOFF_US = 2000;

  logic        clk50M = 1'b0;
  logic        rst_n = 1'b0;
  logic        host_pull = 1'b0;
  logic [15:0] hum_i = 16'h0000;
  logic [15:0] temp_i = 16'h0000;
  logic        fault_crc = 1'b0;
  logic        data_oe, busy, frame_done, err_collision;
  wire         line_w = ~(data_oe | host_pull);

  int vectors = 0;
  int errors = 0;
  int done_cnt = 0;
  int coll_cnt = 0;

  dht_responder #(.CLK_HZ(CLK_HZ)) dut (
    .clk50M       (clk50M),
    .rst_n        (rst_n),
    .data_i       (line_w),
    .data_oe      (data_oe),
    .hum_i        (hum_i),
    .temp_i       (temp_i),
`ifdef DHT_FAULT_INJECT_EN
    .fault_crc_i  (fault_crc),
`endif
    .busy         (busy),
    .frame_done   (frame_done),
    .err_collision(err_collision)
  );

  always #250 clk50M = ~clk50M;

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_rng(input string name, input int act, input int lo, input int hi);
    vectors++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d cycles, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Frame the sensor must send: data words followed by the byte sum mod 256
  function automatic logic [39:0] model_frame(input logic [15:0] h, input logic [15:0] t, input bit f);
    int s;
    s = ((h >> 8) + (h & 255) + (t >> 8) + (t & 255)) % 256;
    if (f) s = 255 - s;
    return {h, t, 8'(s)};
  endfunction

  task automatic wait_us(input int us);
    repeat (us * T) @(negedge clk50M);
  endtask

  task automatic host_request(input int low_us);
    @(negedge clk50M);
    host_pull = 1'b1;
    wait_us(low_us);
    host_pull = 1'b0;
  endtask

  task automatic wait_level(input logic lvl, input int limit, output int n, output bit ok);
    n = 0;
    while (data_oe !== lvl && n < limit) begin
      @(negedge clk50M);
      n++;
    end
    ok = (data_oe === lvl);
  endtask

  task automatic measure(input logic lvl, input int limit, output int n);
    n = 0;
    while (data_oe === lvl && n < limit) begin
      @(negedge clk50M);
      n++;
    end
  endtask

  // Called right at host release: decodes one reply, checks timings, waits out holdoff
  task automatic capture_frame(input logic [15:0] h, input logic [15:0] t, input bit f,
                               input bit scramble, input string tag, output logic [39:0] got);
    int n, hi;
    bit ok;
    logic [39:0] exp;
    exp = model_frame(h, t, f);
    got = 40'h0;
    wait_level(1'b1, (REL_US + 20) * T, n, ok);
    check({tag, "_ack_seen"}, ok, 1);
    if (!ok) return;
    check_rng({tag, "_rel_wait"}, n, REL_US * T, REL_US * T + T + 4);
    if (scramble) begin
      hum_i  = ~hum_i;
      temp_i = ~temp_i;
    end
    measure(1'b1, 200 * T, n);
    check_rng({tag, "_ack_low"}, n, ACK_US * T - T, ACK_US * T + T);
    measure(1'b0, 200 * T, n);
    check_rng({tag, "_ack_high"}, n, ACK_US * T - T, ACK_US * T + T);
    for (int i = 39; i >= 0; i--) begin
      measure(1'b1, 100 * T, n);
      check_rng({tag, "_bit_low"}, n, BLO_US * T - T, BLO_US * T + T);
      measure(1'b0, 150 * T, hi);
      got[i] = (hi > 48 * T);
      if (exp[i]) check_rng({tag, "_bit1_high"}, hi, B1_US * T - T, B1_US * T + T);
      else        check_rng({tag, "_bit0_high"}, hi, B0_US * T - T, B0_US * T + T);
    end
    measure(1'b1, 100 * T, n);
    check_rng({tag, "_tail"}, n, BLO_US * T - T, BLO_US * T + T);
    check({tag, "_frame_done_at_release"}, frame_done, 1);
    check({tag, "_frame_vs_model"}, got, exp);
    n = 0;
    while (busy && n < (HOLDOFF_US + 100) * T) begin
      @(negedge clk50M);
      n++;
    end
    check_rng({tag, "_holdoff"}, n, HOLDOFF_US * T - T, HOLDOFF_US * T + T);
  endtask

  // Per-cycle monitor: driving the line is only legal while busy; count pulses
  always @(negedge clk50M) begin
    if (rst_n && data_oe) check("oe_implies_busy", busy, 1);
    if (rst_n && frame_done) done_cnt++;
    if (rst_n && err_collision) coll_cnt++;
  end

  initial begin
    #45000000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [39:0] got;
    int n, hold_n;
    bit ok, oe_seen;

    repeat (3) @(negedge clk50M);
    check("reset_data_oe", data_oe, 0);
    check("reset_busy", busy, 0);
    check("reset_frame_done", frame_done, 0);
    check("reset_err_collision", err_collision, 0);
    rst_n = 1'b1;
    wait_us(10);

    // 1: nominal frame, inputs scrambled after snapshot
    hum_i = 16'h028A; temp_i = 16'h010B;
    host_request(1000);
    capture_frame(16'h028A, 16'h010B, 1'b0, 1'b1, "t1", got);
    check("t1_frame_literal", got, 40'h028A010B98);
    check("t1_done_count", done_cnt, 1);
    check("t1_coll_count", coll_cnt, 0);

    // 2: short host pulse is ignored
    wait_us(20);
    host_request(500);
    for (int i = 0; i < 300 * T; i++) begin
      @(negedge clk50M);
      check("t2_oe_quiet", data_oe, 0);
      check("t2_busy_quiet", busy, 0);
    end

    // 3: checksum wrap and all-ones timing
    hum_i = 16'hFFFF; temp_i = 16'h8065;
    host_request(1000);
    capture_frame(16'hFFFF, 16'h8065, 1'b0, 1'b0, "t3", got);
    check("t3_csum_literal", got[7:0], 8'hE3);
    check("t3_frame_literal", got, 40'hFFFF8065E3);
    check("t3_done_count", done_cnt, 2);

    // 4: host collides during bit index 10 high phase
    wait_us(20);
    hum_i = 16'h1357; temp_i = 16'h2468;
    host_request(1000);
    ok = 1'b1;
    for (int r = 1; r <= 31; r++) begin
      if (ok) wait_level(1'b1, 400 * T, n, ok);
      if (ok) wait_level(1'b0, 400 * T, n, ok);
    end
    check("t4_reach_bit10", ok, 1);
    wait_us(10);
    host_pull = 1'b1;
    n = 0;
    while (!err_collision && n < 20) begin
      @(negedge clk50M);
      n++;
    end
    check("t4_err_collision", err_collision, 1);
    check("t4_oe_released", data_oe, 0);
    check("t4_busy_holdoff", busy, 1);
    @(negedge clk50M);
    check("t4_err_pulse_width", err_collision, 0);
    oe_seen = 1'b0;
    hold_n = 1;
    fork
      begin
        wait_us(5);
        host_pull = 1'b0;
        wait_us(500);
        host_pull = 1'b1;
        wait_us(1000);
        host_pull = 1'b0;
      end
      begin
        while (busy && hold_n < (HOLDOFF_US + 100) * T) begin
          if (data_oe) oe_seen = 1'b1;
          @(negedge clk50M);
          hold_n++;
        end
      end
    join
    check("t4_ignored_request", oe_seen, 0);
    check_rng("t4_holdoff", hold_n, HOLDOFF_US * T - T - 2, HOLDOFF_US * T + T);
    for (int i = 0; i < 100 * T; i++) begin
      @(negedge clk50M);
      check("t4_idle_oe", data_oe, 0);
      check("t4_idle_busy", busy, 0);
    end
    check("t4_coll_count", coll_cnt, 1);
    check("t4_done_count", done_cnt, 2);

    // 5: reset during ACK low releases the line at once; next request is served
    hum_i = 16'hABCD; temp_i = 16'h0123;
    host_request(1000);
    wait_level(1'b1, (REL_US + 20) * T, n, ok);
    check("t5_ack_seen", ok, 1);
    wait_us(20);
    #100;
    rst_n = 1'b0;
    #1;
    check("t5_async_oe", data_oe, 0);
    check("t5_async_busy", busy, 0);
    repeat (4) @(negedge clk50M);
    rst_n = 1'b1;
    wait_us(10);
    host_request(1000);
    capture_frame(16'hABCD, 16'h0123, 1'b0, 1'b0, "t5", got);
    check("t5_frame_literal", got, 40'hABCD01239C);
    check("t5_done_count", done_cnt, 3);

`ifdef DHT_FAULT_INJECT_EN
    // 6: injected checksum fault inverts the checksum byte
    wait_us(20);
    hum_i = 16'h028A; temp_i = 16'h010B; fault_crc = 1'b1;
    host_request(1000);
    fault_crc = 1'b0;
    capture_frame(16'h028A, 16'h010B, 1'b1, 1'b0, "t6", got);
    check("t6_csum_literal", got[7:0], 8'h67);
    check("t6_done_count", done_cnt, 4);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/dht_responder.md
Name: dht_responder

Overview:
Emulates a DHT22-class single-wire humidity/temperature sensor: the responder end of the single-wire protocol that the Humidity block drives as host. Detects the host start pulse, answers with the ACK preamble, then shifts out a 40-bit frame: humidity, temperature, checksum. Used for hardware-in-loop and bench checkout of the host reader without a physical sensor. The top level wires it to an open-drain pin as Data_H = data_oe ? 1'b0 : 1'bz.

Parameters:
CLK_HZ, 50000000, clk50M frequency; TICKS_PER_US = CLK_HZ/1000000 (integer, must be exact)
START_MIN_US, 800, minimum host low time accepted as a start request
REL_WAIT_US, 30, delay from host release to start of ACK
ACK_US, 80, duration of ACK low phase and of ACK high phase
BIT_LOW_US, 50, low phase before every data bit and tail low time
BIT0_HIGH_US, 27, high time encoding a 0
BIT1_HIGH_US, 70, high time encoding a 1
HOLDOFF_US, 2000, quiet time after a frame during which requests are ignored

Ports:
clk50M  in  1  system clock
rst_n  in  1  asynchronous active-low reset
data_i  in  1  raw line level, asynchronous to clk50M
data_oe  out  1  1 = pull line low; 0 = release
hum_i  in  16  humidity word (x10 %RH)
temp_i  in  16  temperature word (bit15 sign, x10 degC)
busy  out  1  high from start-request acceptance through end of holdoff
frame_done  out  1  one-cycle pulse when tail low ends
err_collision  out  1  one-cycle pulse on line-low collision abort

Behaviour:
- Reset (async, rst_n=0): data_oe=0, busy=0, frame_done=0, err_collision=0, state IDLE, all counters 0. Reset mid-frame releases the line immediately.
- data_i passes through a 2-FF synchronizer; all decisions use the synchronized level ds (2-cycle latency).
- Microsecond tick: a one-cycle strobe every TICKS_PER_US clocks; phase counters count ticks.
- IDLE: ds falls -> HOST_LOW, us counter cleared.
- HOST_LOW: count while ds=0, saturating at START_MIN_US. On ds rise: count >= START_MIN_US -> snapshot hum_i/temp_i, compute checksum, busy=1, go to HOST_REL; otherwise return to IDLE silently (glitch/short pulse).
- HOST_REL: wait REL_WAIT_US; ds=0 here -> collision.
- ACK_LOW: data_oe=1 for ACK_US. ACK_HIGH: data_oe=0 for ACK_US.
- BIT_LOW: data_oe=1 for BIT_LOW_US. BIT_HIGH: data_oe=0 for BIT0_HIGH_US or BIT1_HIGH_US, per the current bit. 40 bits, MSB first; frame order is {hum[15:8], hum[7:0], temp[15:8], temp[7:0], csum}. Bit index decrements 39..0; after bit 0 go to TAIL.
- TAIL: data_oe=1 for BIT_LOW_US, then release; frame_done pulses on the release cycle; go to HOLDOFF.
- HOLDOFF: ignore the line for HOLDOFF_US, then busy=0 and go to IDLE.
- Checksum: 8-bit sum of the four data bytes, carry discarded (wrap mod 256).
- Collision: in any state with data_oe=0 after acceptance (HOST_REL, ACK_HIGH, BIT_HIGH), ds=0 is sampled more than 2 cycles after data_oe falls (synchronizer skew margin). Response: data_oe=0, pulse err_collision, go to HOLDOFF.
- Inputs hum_i/temp_i are ignored after the snapshot; changes mid-frame do not affect the frame.
- data_oe changes only on phase boundaries; no glitches (registered output).

Optional Feature:
DHT_FAULT_INJECT_EN: adds input port fault_crc_i (1 bit), sampled at snapshot. When 1, the transmitted checksum is inverted (~csum) so the host's checksum-error path can be exercised. Without the macro, the port is absent and the checksum is always correct.

Decomposition:
- Package dht_pkg: state enum (IDLE, HOST_LOW, HOST_REL, ACK_LOW, ACK_HIGH, BIT_LOW, BIT_HIGH, TAIL, HOLDOFF); FRAME_BITS=40; default microsecond timing constants.
- Sub-module dht_us_timer: prescaler producing the 1 us tick, plus a loadable phase counter with a done flag. The FSM instantiates one.

Test Plan:
1. Host low 1000 us, then release; hum_i=16'h028A, temp_i=16'h010B -> ACK 80 us low/80 us high; bytes 02 8A 01 0B 98 on the wire; frame_done pulses once; busy drops 2000 us later.
2. Host low 500 us -> no response; data_oe stays 0; busy stays 0.
3. temp_i=16'h8065, hum_i=16'hFFFF -> checksum (FF+FF+80+65) mod 256 = 8'hE3; bit timing measured as 27 us (0) / 70 us (1) within ±1 tick.
4. Host pulls low during bit 10 high phase -> err_collision pulse, data_oe=0, HOLDOFF entered; a new request within 2000 us is ignored.
5. rst_n asserted during ACK_LOW -> data_oe=0 asynchronously; a valid request after reset gets a full frame.
6. With DHT_FAULT_INJECT_EN and fault_crc_i=1, case 1 inputs -> checksum byte 8'h67.
